// File: rtl/hilo_pkg.sv
// Shared definitions for the divide-issue / HI-LO writeback stage.
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN
    } div_state_t;

    // Iterations the radix-2 core needs for a 32-bit quotient.
    localparam int DIV_ITERATIONS = 32;

    // LO value written for a division by zero.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // Two's-complement negate when neg is set. 0x8000_0000 maps to itself,
    // which is exactly the unsigned magnitude we want for the most negative value.
    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] value);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/hilo_divider_divu.sv
// Unsigned restoring radix-2 divider core: one quotient bit per cycle,
// busy rises on the edge that samples start and falls after the last bit.
module Divu
    import hilo_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [4:0]  count;
    logic [31:0] divisor_q;
    logic [32:0] shifted;
    logic [32:0] diff;

    // Trial subtraction of the divisor from the partial remainder shifted left by one.
    always_comb begin
        shifted = {remainder, quotient[31]};
        diff    = shifted - {1'b0, divisor_q};
    end

    // Load operands on start, then shift/subtract once per cycle while busy.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            count     <= '0;
            divisor_q <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start && !busy) begin
            busy      <= 1'b1;
            count     <= '0;
            divisor_q <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (busy) begin
            if (!diff[32]) begin
                remainder <= diff[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= shifted[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            count <= count + 5'd1;
            if (count == 5'(DIV_ITERATIONS - 1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_divider.sv
// Divide issue and HI/LO writeback: converts div/divu operands to magnitudes,
// runs the unsigned core, sign-corrects the result and owns HI/LO.
module hilo_divider
    import hilo_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_signed,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        done
);

    div_state_t  state;
    div_state_t  state_next;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic        q_neg;
    logic        r_neg;
    logic        rs_neg;
    logic        rt_neg;
    logic        accept_div;
    logic        accept_div0;
    logic        mt_allowed;
    logic        result_write;
    logic        core_start;
    logic        core_busy;
    logic [31:0] core_quo;
    logic [31:0] core_rem;

    assign rs_neg = op_signed & rs_val[31];
    assign rt_neg = op_signed & rt_val[31];

    // Next-state, stall and strobe decode.
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        accept_div   = 1'b0;
        accept_div0  = 1'b0;
        mt_allowed   = 1'b0;
        result_write = 1'b0;
        core_start   = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    if (rt_val != 32'd0) begin
                        accept_div = 1'b1;
                        stall      = 1'b1;
                        state_next = LAUNCH;
                    end else begin
                        accept_div0 = 1'b1;
                    end
                end else begin
                    mt_allowed = 1'b1;
                end
            end
            LAUNCH: begin
                stall      = 1'b1;
                core_start = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                stall = 1'b1;
                if (!core_busy) begin
                    result_write = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Latch operand magnitudes and result signs when a real divide is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dvd_mag <= '0;
            dvs_mag <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
        end else if (accept_div) begin
            dvd_mag <= negate_if(rs_neg, rs_val);
            dvs_mag <= negate_if(rt_neg, rt_val);
            q_neg   <= rs_neg ^ rt_neg;
            r_neg   <= rs_neg;
        end
    end

    // Architectural HI/LO and the done pulse; divide results win over mthi/mtlo.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= accept_div0 | result_write;
            if (result_write) begin
                lo <= negate_if(q_neg, core_quo);
                hi <= negate_if(r_neg, core_rem);
            end else if (accept_div0) begin
                hi <= rs_val;
                lo <= DIV0_LO;
            end else if (mt_allowed) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

    Divu u_divu (
        .clock     (clock),
        .reset     (reset),
        .start     (core_start),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .busy      (core_busy),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

endmodule
